// File: rtl/photonic_pkg.sv
// Shared definitions for the photonic interconnect link.
// Holds the frame field offsets (common to transmitter and receiver) and the
// buffered receive-entry layout.
//
// Frame layout, MSB to LSB: {dest_id, data, src_id}
// Buffered entry layout, MSB to LSB: {data, src_id}
package photonic_pkg;

    localparam int ID_W_DEF   = 2;
    localparam int DATA_W_DEF = 2;
    localparam int DROP_MAX   = 255;

    // Offsets are functions of the field widths so parameterised users and
    // the transmitter agree on the layout for any width choice.
    function automatic int src_lsb();
        return 0;
    endfunction

    function automatic int data_lsb(input int id_w);
        return id_w;
    endfunction

    function automatic int dest_lsb(input int id_w, input int data_w);
        return id_w + data_w;
    endfunction

    localparam int SRC_LSB  = 0;
    localparam int DATA_LSB = ID_W_DEF;
    localparam int DEST_LSB = ID_W_DEF + DATA_W_DEF;

    typedef struct packed {
        logic [DATA_W_DEF-1:0] data;
        logic [ID_W_DEF-1:0]   src_id;
    } rx_entry_t;

endpackage

// File: rtl/rx_fifo.sv
// Synchronous first-word-fall-through FIFO.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   push, wdata     write request and data
//   pop             remove head (ignored when empty)
//   rdata           head entry (valid while !empty)
//   full, empty     derived from the occupancy count
//   level           number of occupied entries
module rx_fifo #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4,
    localparam int PW = $clog2(DEPTH),
    localparam int LW = PW + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [LW-1:0]    level
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [LW-1:0]    r_level;
    logic             w_pop_ok;
    logic             w_push_ok;

    assign empty = (r_level == '0);
    assign full  = (r_level == LW'(DEPTH));

    // A push into a full FIFO is legal only when the head leaves on the same edge.
    assign w_pop_ok  = pop && !empty;
    assign w_push_ok = push && (!full || w_pop_ok);

    // Memory is reset too so the head output reads 0 straight out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_push_ok) begin
            r_mem[r_wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            if (w_push_ok && !w_pop_ok) begin
                r_level <= r_level + LW'(1);
            end else if (w_pop_ok && !w_push_ok) begin
                r_level <= r_level - LW'(1);
            end
        end
    end

    assign rdata = r_mem[r_rd_ptr];
    assign level = r_level;

endmodule

// File: rtl/receiver.sv
// Receiving end of the photonic link.
// Captures the bus frame every cycle, keeps frames addressed to my_id, buffers
// {data, src_id} in an FWFT FIFO and hands them out over valid/ready.
// Matching frames that find the FIFO full are dropped, counted and flagged.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   my_id                      static node ID
//   rx_in, rx_valid            bus frame {dest_id, data, src_id} and its strobe
//   out_data, out_src_id       FIFO head payload and source
//   out_valid, out_ready       head handshake
//   fifo_level                 FIFO occupancy
//   overflow, drop_count       sticky drop flag, saturating drop counter
//   clear_status               clears overflow/drop_count on the next edge
module receiver
    import photonic_pkg::*;
#(
    parameter int ID_WIDTH   = 2,
    parameter int DATA_WIDTH = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [ID_WIDTH-1:0]             my_id,
    input  logic [2*ID_WIDTH+DATA_WIDTH-1:0] rx_in,
    input  logic                            rx_valid,
    output logic [DATA_WIDTH-1:0]           out_data,
    output logic [ID_WIDTH-1:0]             out_src_id,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_level,
    output logic                            overflow,
    output logic [7:0]                      drop_count,
    input  logic                            clear_status
);

    localparam int FW     = 2 * ID_WIDTH + DATA_WIDTH;
    localparam int EW     = ID_WIDTH + DATA_WIDTH;
    localparam int DST_LO = dest_lsb(ID_WIDTH, DATA_WIDTH);

    logic [FW-1:0] r_cap_frame;
    logic          r_cap_vld;
    logic          r_overflow;
    logic [7:0]    r_drop_count;

    logic          w_match;
    logic          w_full;
    logic          w_empty;
    logic          w_pop;
    logic          w_push;
    logic          w_drop;
    logic [EW-1:0] w_head;

    // Capture stage: the bus is sampled every edge, strobe included.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cap_vld   <= 1'b0;
            r_cap_frame <= '0;
        end else begin
            r_cap_vld   <= rx_valid;
            r_cap_frame <= rx_in;
        end
    end

    assign w_match = r_cap_vld && (r_cap_frame[DST_LO +: ID_WIDTH] == my_id);
    assign w_pop   = !w_empty && out_ready;
    assign w_push  = w_match && (!w_full || w_pop);
    assign w_drop  = w_match && w_full && !w_pop;

    // The low EW bits of the frame are exactly {data, src_id}.
    rx_fifo #(
        .WIDTH(EW),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (w_push),
        .wdata (r_cap_frame[EW-1:0]),
        .pop   (w_pop),
        .rdata (w_head),
        .full  (w_full),
        .empty (w_empty),
        .level (fifo_level)
    );

    // A drop coinciding with a clear survives as a single fresh drop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_overflow   <= 1'b0;
            r_drop_count <= '0;
        end else if (clear_status) begin
            r_overflow   <= w_drop;
            r_drop_count <= w_drop ? 8'd1 : 8'd0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
            if (r_drop_count != 8'(DROP_MAX)) begin
                r_drop_count <= r_drop_count + 8'd1;
            end
        end
    end

    assign out_valid  = !w_empty;
    assign out_data   = w_head[EW-1:ID_WIDTH];
    assign out_src_id = w_head[ID_WIDTH-1:0];
    assign overflow   = r_overflow;
    assign drop_count = r_drop_count;

endmodule

// File: tb/tb_receiver.sv
module tb_receiver;
    import photonic_pkg::*;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] my_id;
    logic [5:0] rx_in;
    logic       rx_valid;
    logic [1:0] out_data;
    logic [1:0] out_src_id;
    logic       out_valid;
    logic       out_ready;
    logic [2:0] fifo_level;
    logic       overflow;
    logic [7:0] drop_count;
    logic       clear_status;

    int passed = 0;
    int total  = 0;

    // Reference model: a queue of buffered entries plus the captured frame.
    rx_entry_t q[$];
    logic      m_cap_vld;
    logic [5:0] m_cap_frame;
    logic      m_ovf;
    int        m_cnt;

    receiver #(.ID_WIDTH(2), .DATA_WIDTH(2), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .my_id(my_id), .rx_in(rx_in),
        .rx_valid(rx_valid), .out_data(out_data), .out_src_id(out_src_id),
        .out_valid(out_valid), .out_ready(out_ready), .fifo_level(fifo_level),
        .overflow(overflow), .drop_count(drop_count), .clear_status(clear_status)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] id;
        logic       rxv;
        logic [5:0] rxin;
        logic       rdy;
        logic       clr;
        logic       e_vld;
        logic [1:0] e_data;
        logic [1:0] e_src;
        logic [2:0] e_lvl;
        logic       e_ovf;
        logic [7:0] e_cnt;
    } vec_t;

    vec_t tbl[13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else passed++;
    endtask

    function automatic logic [5:0] frm(input logic [1:0] d, input logic [1:0] da, input logic [1:0] s);
        return {d, da, s};
    endfunction

    task automatic model_reset();
        q.delete();
        m_cap_vld   = 1'b0;
        m_cap_frame = '0;
        m_ovf       = 1'b0;
        m_cnt       = 0;
    endtask

    // Evaluate one clock edge of the reference from the inputs currently applied.
    task automatic model_edge();
        bit pop, match, full, drop;
        rx_entry_t e;
        pop   = (q.size() > 0) && out_ready;
        match = m_cap_vld && (m_cap_frame[5:4] == my_id);
        full  = (q.size() == DEPTH);
        drop  = 1'b0;
        if (pop) void'(q.pop_front());
        if (match) begin
            if (!full || pop) begin
                e.data   = m_cap_frame[3:2];
                e.src_id = m_cap_frame[1:0];
                q.push_back(e);
            end else begin
                drop = 1'b1;
            end
        end
        if (clear_status) begin
            m_ovf = drop;
            m_cnt = drop ? 1 : 0;
        end else if (drop) begin
            m_ovf = 1'b1;
            if (m_cnt < 255) m_cnt++;
        end
        m_cap_vld   = rx_valid;
        m_cap_frame = rx_in;
    endtask

    task automatic model_check();
        chk("model out_valid", 32'(out_valid), 32'(q.size() > 0));
        chk("model fifo_level", 32'(fifo_level), 32'(q.size()));
        chk("model overflow", 32'(overflow), 32'(m_ovf));
        chk("model drop_count", 32'(drop_count), 32'(m_cnt));
        if (q.size() > 0) begin
            chk("model out_data", 32'(out_data), 32'(q[0].data));
            chk("model out_src_id", 32'(out_src_id), 32'(q[0].src_id));
        end
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        model_check();
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " out_valid"}, 32'(out_valid), 0);
        chk({tag, " fifo_level"}, 32'(fifo_level), 0);
        chk({tag, " overflow"}, 32'(overflow), 0);
        chk({tag, " drop_count"}, 32'(drop_count), 0);
        chk({tag, " out_data"}, 32'(out_data), 0);
        chk({tag, " out_src_id"}, 32'(out_src_id), 0);
    endtask

    initial begin
        rst_n = 1'b0; my_id = 2'b01; rx_in = '0; rx_valid = 1'b0;
        out_ready = 1'b0; clear_status = 1'b0;
        model_reset();
        #2;
        chk_all_zero("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Basic receive, address filter, valid gating.
        tbl[0]  = '{2'b01, 1, 6'b01_01_10, 1, 0, 0, 2'b00, 2'b00, 3'd0, 0, 8'd0};
        tbl[1]  = '{2'b01, 0, 6'b00_00_00, 1, 0, 1, 2'b01, 2'b10, 3'd1, 0, 8'd0};
        tbl[2]  = '{2'b01, 0, 6'b00_00_00, 1, 0, 0, 2'b00, 2'b00, 3'd0, 0, 8'd0};
        tbl[3]  = '{2'b10, 1, 6'b00_00_00, 0, 0, 0, 2'b00, 2'b00, 3'd0, 0, 8'd0};
        tbl[4]  = '{2'b10, 1, 6'b01_01_10, 0, 0, 0, 2'b00, 2'b00, 3'd0, 0, 8'd0};
        tbl[5]  = '{2'b10, 1, 6'b11_11_11, 0, 0, 0, 2'b00, 2'b00, 3'd0, 0, 8'd0};
        tbl[6]  = '{2'b10, 1, 6'b10_10_01, 0, 0, 0, 2'b00, 2'b00, 3'd0, 0, 8'd0};
        tbl[7]  = '{2'b10, 0, 6'b00_00_00, 0, 0, 1, 2'b10, 2'b01, 3'd1, 0, 8'd0};
        tbl[8]  = '{2'b10, 0, 6'b00_00_00, 1, 0, 0, 2'b00, 2'b00, 3'd0, 0, 8'd0};
        for (int i = 9; i < 13; i++)
            tbl[i] = '{2'b10, 0, 6'b10_11_00, 1, 0, 0, 2'b00, 2'b00, 3'd0, 0, 8'd0};

        for (int i = 0; i < 13; i++) begin
            my_id = tbl[i].id; rx_valid = tbl[i].rxv; rx_in = tbl[i].rxin;
            out_ready = tbl[i].rdy; clear_status = tbl[i].clr;
            step();
            chk($sformatf("vec%0d out_valid", i), 32'(out_valid), 32'(tbl[i].e_vld));
            chk($sformatf("vec%0d fifo_level", i), 32'(fifo_level), 32'(tbl[i].e_lvl));
            chk($sformatf("vec%0d overflow", i), 32'(overflow), 32'(tbl[i].e_ovf));
            chk($sformatf("vec%0d drop_count", i), 32'(drop_count), 32'(tbl[i].e_cnt));
            if (tbl[i].e_vld) begin
                chk($sformatf("vec%0d out_data", i), 32'(out_data), 32'(tbl[i].e_data));
                chk($sformatf("vec%0d out_src_id", i), 32'(out_src_id), 32'(tbl[i].e_src));
            end
        end

        // Overflow and clear.
        my_id = 2'b01; out_ready = 1'b0; clear_status = 1'b0;
        for (int i = 0; i < 6; i++) begin
            rx_valid = 1'b1; rx_in = frm(2'b01, 2'(i), 2'(3 - i));
            step();
        end
        rx_valid = 1'b0;
        step();
        chk("ovf level", 32'(fifo_level), 4);
        chk("ovf flag", 32'(overflow), 1);
        chk("ovf count", 32'(drop_count), 2);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("ovf pop%0d data", i), 32'(out_data), 32'(i));
            chk($sformatf("ovf pop%0d src", i), 32'(out_src_id), 32'(3 - i));
            step();
        end
        chk("ovf drained", 32'(fifo_level), 0);
        out_ready = 1'b0; clear_status = 1'b1;
        step();
        clear_status = 1'b0;
        chk("clear count", 32'(drop_count), 0);
        chk("clear flag", 32'(overflow), 0);

        // Full FIFO with simultaneous pop and push.
        for (int i = 0; i < 4; i++) begin
            rx_valid = 1'b1; rx_in = frm(2'b01, 2'(i), 2'b00);
            step();
        end
        rx_in = frm(2'b01, 2'b11, 2'b11);
        step();
        chk("full level pre", 32'(fifo_level), 4);
        rx_valid = 1'b0; out_ready = 1'b1;
        step();
        chk("pushpop level", 32'(fifo_level), 4);
        chk("pushpop count", 32'(drop_count), 0);
        chk("pushpop flag", 32'(overflow), 0);
        for (int i = 0; i < 3; i++) step();
        chk("last-out data", 32'(out_data), 3);
        chk("last-out src", 32'(out_src_id), 3);
        step();
        chk("last-out empty", 32'(out_valid), 0);

        // Drop counter saturation, then clear coinciding with a drop.
        out_ready = 1'b0; rx_valid = 1'b1; rx_in = frm(2'b01, 2'b10, 2'b10);
        for (int i = 0; i < 265; i++) step();
        chk("sat count", 32'(drop_count), 255);
        chk("sat flag", 32'(overflow), 1);
        rx_valid = 1'b0; clear_status = 1'b1;
        step();
        clear_status = 1'b0;
        chk("clear+drop count", 32'(drop_count), 1);
        chk("clear+drop flag", 32'(overflow), 1);
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) step();

        // Asynchronous reset mid-operation.
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            rx_valid = 1'b1; rx_in = frm(2'b01, 2'(i + 1), 2'(i));
            step();
        end
        chk("pre-reset level", 32'(fifo_level), 3);
        rx_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk_all_zero("async reset");
        model_reset();
        @(posedge clk); #1;
        chk_all_zero("held reset");
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk($sformatf("post-reset stale%0d", i), 32'(out_valid), 0);
        end

        // Randomised traffic against the model.
        my_id = 2'b11;
        for (int i = 0; i < 400; i++) begin
            rx_valid     = ($urandom_range(0, 3) != 0);
            rx_in        = {($urandom_range(0, 1) != 0) ? my_id : 2'($urandom), 4'($urandom)};
            out_ready    = ($urandom_range(0, 2) == 0);
            clear_status = ($urandom_range(0, 29) == 0);
            step();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
